vga_timing_gen: RTL

Raster timing generator that sits directly upstream of the sprite/ROM drawing stages and the VGA DAC output. It produces the pixel coordinates `DrawX`/`DrawY`, the active-video flag `blank`, and active-low `hs`/`vs` syncs, all registered on `vga_clk`. It also provides a frame-start pulse, a vertical-blank-start pulse and a frame counter, which game logic uses to update tank and bullet positions once per frame.

---
 rtl/vga_timing_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered coordinate, blank,
// sync, frame/vblank pulses and a completed-frame counter, all aligned to one position.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  VBLANK_ROW = 10'(V_ACTIVE);

  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       active_next;
  logic       hsync_zone;
  logic       vsync_zone;
  logic       frame_start_next;
  logic       vblank_start_next;
  logic       frame_seen;

  // Decodes use the next counter values so the registered outputs describe the
  // same position that DrawX/DrawY show in that cycle.
  always_comb begin
    hc_next           = hc + 10'd1;
    vc_next           = vc;
    if (hc == H_LAST) begin
      hc_next = 10'd0;
      vc_next = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end
    active_next       = ({1'b0, hc_next} < H_ACT_END) && ({1'b0, vc_next} < V_ACT_END);
    hsync_zone        = ({1'b0, hc_next} >= HS_BEGIN) && ({1'b0, hc_next} < HS_END);
    vsync_zone        = ({1'b0, vc_next} >= VS_BEGIN) && ({1'b0, vc_next} < VS_END);
    frame_start_next  = (hc_next == 10'd0) && (vc_next == 10'd0);
    vblank_start_next = (hc_next == 10'd0) && (vc_next == VBLANK_ROW);
  end

  // Counters sit at the last position during reset so the first edge wraps to (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc           <= H_LAST;
      vc           <= V_LAST;
      DrawX        <= 10'd0;
      DrawY        <= 10'd0;
      blank        <= 1'b0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      hc           <= hc_next;
      vc           <= vc_next;
      DrawX        <= hc_next;
      DrawY        <= vc_next;
      blank        <= active_next;
      hs           <= ~hsync_zone;
      vs           <= ~vsync_zone;
      frame_start  <= frame_start_next;
      vblank_start <= vblank_start_next;
    end
  end

  // The frame entered right after reset is not a completed frame, so skip its count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
      frame_seen  <= 1'b0;
    end else if (frame_start_next) begin
      frame_seen <= 1'b1;
      if (frame_seen) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
